// File: rtl/alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage
//
// Downstream stage of the 8-bit ALU. Each accepted ALU transaction may commit
// its flags into the architectural flag register (depending on the opcode)
// and may queue a register-file writeback. Queued writebacks drain to the
// register-file write port under a write/acknowledge handshake, so ALU issue
// is decoupled from register-file write availability.
//
// o_Ready, o_WrEn, o_WrAddr, o_WrData and o_Count depend only on registered
// state. There is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module alu_writeback_stage #(
    parameter int FIFO_DEPTH = 2,   // power of two, 2..8
    parameter int REG_ADDR_W = 3
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset_n,

    // ALU result side
    input  logic                        i_Valid,
    output logic                        o_Ready,
    input  logic [3:0]                  i_ALUOp,
    input  logic [7:0]                  i_Result,
    input  logic                        i_Z,
    input  logic                        i_S,
    input  logic                        i_C,
    input  logic                        i_OF,
    input  logic                        i_WrBack,
    input  logic [REG_ADDR_W-1:0]       i_DestAddr,
    input  logic                        i_FlagClr,

    // Register-file write port
    output logic                        o_WrEn,
    output logic [REG_ADDR_W-1:0]       o_WrAddr,
    output logic [7:0]                  o_WrData,
    input  logic                        i_WrAck,

    // Architectural flags and queue occupancy
    output logic                        o_FlagZ,
    output logic                        o_FlagS,
    output logic                        o_FlagC,
    output logic                        o_FlagOF,
    output logic [$clog2(FIFO_DEPTH):0] o_Count
);

    // -----------------------------------------------------------------------
    // Local parameters
    // -----------------------------------------------------------------------
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // ALU opcode encoding shared with the ALU. Only ADD and ZER produce
    // trustworthy flags; every other code leaves stale flags on the ALU
    // outputs and must not be committed.
    localparam logic [3:0] ALUOP_ADD = 4'h0;
    localparam logic [3:0] ALUOP_ZER = 4'h1;
    localparam logic [3:0] ALUOP_PD1 = 4'h2;
    localparam logic [3:0] ALUOP_PD2 = 4'h3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0]       head_ptr;
    logic [PTR_W-1:0]       tail_ptr;
    logic [CNT_W-1:0]       count;

    logic [REG_ADDR_W-1:0]  addr_mem [FIFO_DEPTH];
    logic [7:0]             data_mem [FIFO_DEPTH];

    logic                   flag_z;
    logic                   flag_s;
    logic                   flag_c;
    logic                   flag_of;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;

    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);

    // Ready comes from the registered count only, so a same-cycle i_WrAck
    // on a full queue does not open the input side.
    assign o_Ready = !full;
    assign accept  = i_Valid && !full;
    assign push    = accept && i_WrBack;
    assign pop     = !empty && i_WrAck;

    // -----------------------------------------------------------------------
    // Queue storage: write the tail entry on every push
    // -----------------------------------------------------------------------
    // NOTE: the storage is reset so that the head view and any debug read of
    // the array are deterministic after reset; the cost is a reset on every
    // storage flop, acceptable at these depths.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[tail_ptr] <= i_DestAddr;
            data_mem[tail_ptr] <= i_Result;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers and occupancy: advance on push/pop, wrap modulo FIFO_DEPTH
    // -----------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            // FIFO_DEPTH is a power of two, so natural pointer overflow is
            // exactly the modulo wrap.
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end

            // push is impossible when full and pop is impossible when empty,
            // so count stays within 0..FIFO_DEPTH.
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Flag register: clear wins, otherwise commit by opcode on accept
    // -----------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            flag_z  <= 1'b0;
            flag_s  <= 1'b0;
            flag_c  <= 1'b0;
            flag_of <= 1'b0;
        end else if (i_FlagClr) begin
            flag_z  <= 1'b0;
            flag_s  <= 1'b0;
            flag_c  <= 1'b0;
            flag_of <= 1'b0;
        end else if (accept) begin
            case (i_ALUOp)
                ALUOP_ADD: begin
                    flag_z  <= i_Z;
                    flag_s  <= i_S;
                    flag_c  <= i_C;
                    flag_of <= i_OF;
                end
                ALUOP_ZER: begin
                    flag_z  <= i_Z;
                end
                ALUOP_PD1,
                ALUOP_PD2: begin
                    // Pass-through ops carry stale flags: hold.
                end
                default: begin
                    // Unknown ops never touch the flags.
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Head view: present the oldest entry, forced to zero when empty
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        o_WrEn   = 1'b0;
        o_WrAddr = '0;
        o_WrData = '0;
        if (!empty) begin
            o_WrEn   = 1'b1;
            o_WrAddr = addr_mem[head_ptr];
            o_WrData = data_mem[head_ptr];
        end
    end

    // -----------------------------------------------------------------------
    // Remaining outputs
    // -----------------------------------------------------------------------
    assign o_Count  = count;
    assign o_FlagZ  = flag_z;
    assign o_FlagS  = flag_s;
    assign o_FlagC  = flag_c;
    assign o_FlagOF = flag_of;

endmodule
